// File: rtl/mac_half_pkg.sv
// rtl/mac_half_pkg.sv - shared widths, latencies and operand pair type for the fp16 MAC feeder
package mac_half_pkg;

    localparam int HALF_W             = 16;
    localparam int MAC_MULT_LAT       = 3;
    localparam int MAC_ACC_LAT        = 3;
    localparam int RESULT_LAT_DEFAULT = MAC_MULT_LAT + MAC_ACC_LAT + 1;

    typedef struct packed {
        logic [HALF_W-1:0] a;
        logic [HALF_W-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/operand_pair_fifo.sv
// rtl/operand_pair_fifo.sv - first-word-fall-through FIFO of {a,b} operand pairs
module operand_pair_fifo
    import mac_half_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          i_clock,
    input  logic          i_areset,
    input  logic          i_push,
    input  logic          i_pop,
    input  operand_pair_t i_data,
    output operand_pair_t o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);

    operand_pair_t r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    // Push is gated by the registered full flag, so a pop never frees a slot in the same cycle.
    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/mac_half_operand_feeder.sv
// rtl/mac_half_operand_feeder.sv - buffers fp16 operand pairs and issues them to the MAC with vector framing
module mac_half_operand_feeder
    import mac_half_pkg::*;
#(
    parameter int VEC_LEN_W  = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int RESULT_LAT = RESULT_LAT_DEFAULT
) (
    input  logic                 i_clock,
    input  logic                 i_areset,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    input  logic [HALF_W-1:0]    i_s_a,
    input  logic [HALF_W-1:0]    i_s_b,
    input  logic [VEC_LEN_W-1:0] i_cfg_len,
    input  logic                 i_m_iready,
    output logic                 o_m_ivalid,
    output logic                 o_m_control,
    output logic [HALF_W-1:0]    o_m_a,
    output logic [HALF_W-1:0]    o_m_b,
    output logic                 o_res_strobe,
    output logic [15:0]          o_res_count,
    output logic                 o_busy
);

    operand_pair_t          w_push_pair;
    operand_pair_t          w_fifo_dout;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_issue;
    logic [VEC_LEN_W-1:0]   w_len_cfg;
    logic [VEC_LEN_W-1:0]   w_len_eff;
    logic                   w_last;

    logic                   r_m_ivalid;
    logic                   r_m_control;
    logic                   r_m_last;
    logic [HALF_W-1:0]      r_m_a;
    logic [HALF_W-1:0]      r_m_b;
    logic [VEC_LEN_W-1:0]   r_elem_cnt;
    logic [VEC_LEN_W-1:0]   r_len_q;
    logic [RESULT_LAT-1:0]  r_dly;
    logic [15:0]            r_res_count;

    assign w_push_pair = {i_s_a, i_s_b};

    operand_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock  (i_clock),
        .i_areset (i_areset),
        .i_push   (i_s_valid),
        .i_pop    (w_issue),
        .i_data   (w_push_pair),
        .o_data   (w_fifo_dout),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty)
    );

    assign w_issue = !w_fifo_empty && i_m_iready;

    // Length is live from cfg_len only on a vector's first element; afterwards the latched copy rules.
    assign w_len_cfg = (i_cfg_len == '0) ? VEC_LEN_W'(1) : i_cfg_len;
    assign w_len_eff = (r_elem_cnt == '0) ? w_len_cfg : r_len_q;
    assign w_last    = (r_elem_cnt == w_len_eff - 1'b1);

    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            r_m_ivalid  <= 1'b0;
            r_m_control <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_a       <= '0;
            r_m_b       <= '0;
        end else begin
            r_m_ivalid  <= w_issue;
            r_m_control <= w_issue && (r_elem_cnt == '0);
            r_m_last    <= w_issue && w_last;
            if (w_issue) begin
                r_m_a <= w_fifo_dout.a;
                r_m_b <= w_fifo_dout.b;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            r_elem_cnt <= '0;
            r_len_q    <= VEC_LEN_W'(1);
        end else if (w_issue) begin
            if (r_elem_cnt == '0) r_len_q <= w_len_cfg;
            r_elem_cnt <= w_last ? '0 : r_elem_cnt + 1'b1;
        end
    end

    // r_m_last is aligned with the MAC seeing the element; the line spans the MAC pipeline.
    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            r_dly       <= '0;
            r_res_count <= '0;
        end else begin
            r_dly <= {r_dly[RESULT_LAT-2:0], r_m_last};
            if (r_dly[RESULT_LAT-1]) r_res_count <= r_res_count + 16'd1;
        end
    end

    assign o_s_ready    = !w_fifo_full;
    assign o_m_ivalid   = r_m_ivalid;
    assign o_m_control  = r_m_control;
    assign o_m_a        = r_m_a;
    assign o_m_b        = r_m_b;
    assign o_res_strobe = r_dly[RESULT_LAT-1];
    assign o_res_count  = r_res_count;
    assign o_busy       = !w_fifo_empty || (r_elem_cnt != '0) || r_m_last || (|r_dly);

endmodule

// File: tb/tb_mac_half_operand_feeder.sv
// tb/tb_mac_half_operand_feeder.sv - self-checking bench for mac_half_operand_feeder
module tb_mac_half_operand_feeder;

    localparam int DEPTH = 8;
    localparam int LAT   = 7;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        d_valid = 1'b0;
    logic [15:0] d_a = '0;
    logic [15:0] d_b = '0;
    logic [4:0]  d_cfg = 5'd4;
    logic        d_iready = 1'b0;

    logic        o_s_ready;
    logic        o_m_ivalid;
    logic        o_m_control;
    logic [15:0] o_m_a;
    logic [15:0] o_m_b;
    logic        o_res_strobe;
    logic [15:0] o_res_count;
    logic        o_busy;

    always #5 clk = ~clk;

    mac_half_operand_feeder dut (
        .i_clock      (clk),
        .i_areset     (areset),
        .i_s_valid    (d_valid),
        .o_s_ready    (o_s_ready),
        .i_s_a        (d_a),
        .i_s_b        (d_b),
        .i_cfg_len    (d_cfg),
        .i_m_iready   (d_iready),
        .o_m_ivalid   (o_m_ivalid),
        .o_m_control  (o_m_control),
        .o_m_a        (o_m_a),
        .o_m_b        (o_m_b),
        .o_res_strobe (o_res_strobe),
        .o_res_count  (o_res_count),
        .o_busy       (o_busy)
    );

    // Reference: pair queue in accept order, element position in the current vector, scheduled strobe cycles.
    logic [31:0] pair_q[$];
    int          strobe_q[$];
    int          elem, len_cur, res_cnt_m, cyc;
    logic        exp_ready;
    logic [15:0] exp_a, exp_b;
    bit          last_acc;

    int          n_pass, n_checks;
    int          n_issue, n_ctrl, n_strobe, n_accept;
    int          first_acc_cyc, first_issue_cyc, last_issue_cyc, last_strobe_cyc;
    logic [31:0] ctrl_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_clear();
        pair_q.delete();
        strobe_q.delete();
        elem = 0; len_cur = 1; res_cnt_m = 0;
        exp_ready = 1'b1; exp_a = '0; exp_b = '0;
    endtask

    task automatic clr_obs();
        n_issue = 0; n_ctrl = 0; n_strobe = 0; n_accept = 0; ctrl_mask = '0;
        first_acc_cyc = 0; first_issue_cyc = 0; last_issue_cyc = 0; last_strobe_cyc = 0;
    endtask

    task automatic model_step();
        logic [31:0] p;
        bit acc, iss, ctrl, strb, busy_e;
        cyc++;
        acc  = d_valid && exp_ready;
        iss  = (pair_q.size() > 0) && d_iready;
        ctrl = 1'b0;
        if (iss) begin
            p = pair_q.pop_front();
            exp_a = p[31:16];
            exp_b = p[15:0];
            ctrl = (elem == 0);
            if (elem == 0) len_cur = (d_cfg == 0) ? 1 : int'(d_cfg);
            elem++;
            if (elem == len_cur) begin
                elem = 0;
                strobe_q.push_back(cyc + LAT);
            end
        end
        if (acc) pair_q.push_back({d_a, d_b});
        exp_ready = (pair_q.size() < DEPTH);
        strb   = (strobe_q.size() > 0) && (strobe_q[0] == cyc);
        busy_e = (pair_q.size() > 0) || (elem != 0) || (strobe_q.size() > 0);

        check("s_ready",    32'(o_s_ready),    32'(exp_ready));
        check("m_ivalid",   32'(o_m_ivalid),   32'(iss));
        check("m_control",  32'(o_m_control),  32'(ctrl));
        check("m_a",        32'(o_m_a),        32'(exp_a));
        check("m_b",        32'(o_m_b),        32'(exp_b));
        check("res_strobe", 32'(o_res_strobe), 32'(strb));
        check("res_count",  32'(o_res_count),  32'(res_cnt_m[15:0]));
        check("busy",       32'(o_busy),       32'(busy_e));

        if (strb) begin
            void'(strobe_q.pop_front());
            res_cnt_m++;
        end
        last_acc = acc;
        if (acc) begin
            if (n_accept == 0) first_acc_cyc = cyc - 1;
            n_accept++;
        end
        if (o_m_ivalid) begin
            if (n_issue == 0) first_issue_cyc = cyc;
            if (o_m_control) begin
                n_ctrl++;
                ctrl_mask[n_issue] = 1'b1;
            end
            last_issue_cyc = cyc;
            n_issue++;
        end
        if (o_res_strobe) begin
            n_strobe++;
            last_strobe_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_step();
    endtask

    task automatic present(input bit want);
        if (want && (!d_valid || last_acc)) begin
            d_a = 16'($urandom);
            d_b = 16'($urandom);
        end
        d_valid = want;
    endtask

    task automatic idle(input int n);
        present(1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_n(input int n);
        int got = 0;
        int guard = 0;
        while (got < n && guard < 200) begin
            present(1'b1);
            tick();
            if (last_acc) got++;
            guard++;
        end
        present(1'b0);
        if (got < n) check("push_timeout", 32'(got), 32'(n));
    endtask

    task automatic do_reset();
        present(1'b0);
        areset = 1'b1;
        #1;
        check("rst_s_ready",    32'(o_s_ready),    32'd1);
        check("rst_m_ivalid",   32'(o_m_ivalid),   32'd0);
        check("rst_m_control",  32'(o_m_control),  32'd0);
        check("rst_res_strobe", 32'(o_res_strobe), 32'd0);
        check("rst_res_count",  32'(o_res_count),  32'd0);
        check("rst_busy",       32'(o_busy),       32'd0);
        check("rst_m_a",        32'(o_m_a),        32'd0);
        @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        model_clear();
        last_acc = 1'b0;
    endtask

    initial begin
        int guard;
        n_pass = 0; n_checks = 0; cyc = 0;
        model_clear();
        clr_obs();
        @(negedge clk);
        do_reset();

        // Single vector of 4, back-to-back
        d_cfg = 5'd4; d_iready = 1'b1;
        clr_obs();
        push_n(4);
        idle(12);
        check("t2_first_lat",   32'(first_issue_cyc - first_acc_cyc), 32'd2);
        check("t2_issue_run",   32'(last_issue_cyc - first_issue_cyc), 32'd3);
        check("t2_issue_cnt",   32'(n_issue), 32'd4);
        check("t2_ctrl_cnt",    32'(n_ctrl), 32'd1);
        check("t2_strobe_lat",  32'(last_strobe_cyc - last_issue_cyc), 32'd7);
        check("t2_strobe_cnt",  32'(n_strobe), 32'd1);
        check("t2_res_count",   32'(o_res_count), 32'd1);

        // Fill with MAC stalled, ninth pair must wait
        d_iready = 1'b0;
        clr_obs();
        push_n(8);
        check("t3_ready_full", 32'(o_s_ready), 32'd0);
        present(1'b1);
        for (int i = 0; i < 3; i++) tick();
        check("t3_held", 32'(n_accept), 32'd8);
        d_iready = 1'b1;
        guard = 0;
        while (!last_acc && guard < 10) begin
            present(1'b1);
            tick();
            guard++;
        end
        present(1'b0);
        guard = 0;
        while (n_issue < 9 && guard < 40) begin
            tick();
            guard++;
        end
        check("t3_issue_cnt", 32'(n_issue), 32'd9);

        // Reset in mid-stream
        push_n(3);
        do_reset();

        // Zero length means one-element vectors
        d_cfg = 5'd0; d_iready = 1'b1;
        clr_obs();
        push_n(3);
        idle(12);
        check("t4_ctrl_cnt",   32'(n_ctrl), 32'd3);
        check("t4_strobe_cnt", 32'(n_strobe), 32'd3);
        check("t4_res_count",  32'(o_res_count), 32'd3);

        // Partial vector discarded by reset
        d_cfg = 5'd4;
        push_n(2);
        idle(2);
        do_reset();
        clr_obs();
        push_n(4);
        idle(12);
        check("t5_ctrl_cnt",   32'(n_ctrl), 32'd1);
        check("t5_first_ctrl", 32'(ctrl_mask), 32'h1);
        check("t5_strobe_cnt", 32'(n_strobe), 32'd1);
        check("t5_res_count",  32'(o_res_count), 32'd1);

        // Length change mid-vector ignored, toggling iready
        do_reset();
        clr_obs();
        d_cfg = 5'd4; d_iready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            present(n_accept < 6);
            tick();
            if (n_issue >= 1) d_cfg = 5'd2;
            d_iready = ~d_iready;
        end
        check("t6_issue_cnt",  32'(n_issue), 32'd6);
        check("t6_ctrl_mask",  32'(ctrl_mask), 32'h11);
        check("t6_strobe_cnt", 32'(n_strobe), 32'd2);
        check("t6_res_count",  32'(o_res_count), 32'd2);

        // Randomized traffic against the reference
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            present($urandom_range(0, 3) != 0);
            d_iready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) d_cfg = 5'($urandom_range(0, 7));
            tick();
        end
        present(1'b0);
        d_iready = 1'b1;
        guard = 0;
        while ((pair_q.size() > 0 || strobe_q.size() > 0) && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("drain_timeout", 32'(pair_q.size() + strobe_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
